// File: rtl/present_pkg.sv
// Shared types and constants for the PRESENT decryption scheduler.
package present_pkg;

  localparam int SIZE       = 64;
  localparam int KEY_SIZE   = 80;
  localparam int NUM_ROUNDS = 31;
  localparam int RUN_CYCLES = NUM_ROUNDS - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CAPT,
    S_RESP
  } sched_state_t;

  function automatic int key_bus_w(input int n);
    return n * KEY_SIZE;
  endfunction

  function automatic int text_bus_w(input int n);
    return n * SIZE;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the requester after `last` wins ties.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (last) begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end else begin
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
    end
  end

endmodule

// File: rtl/present_dec_sched.sv
// Schedules jobs from two requesters onto one PRESENT decryption core,
// sequencing Enable and bounding each job with a run-cycle watchdog.
module present_dec_sched
  import present_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MAX_RUN = 40
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [key_bus_w(NUM_REQ)-1:0]   req_key,
  input  logic [text_bus_w(NUM_REQ)-1:0]  req_text,
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic [SIZE-1:0]                 rsp_data,
  output logic                            rsp_error,
  output logic [KEY_SIZE-1:0]             core_key,
  output logic [SIZE-1:0]                 core_text,
  output logic                            core_enable,
  output logic                            core_reset_n,
  input  logic                            core_done,
  input  logic [SIZE-1:0]                 core_result
);

  sched_state_t        state, state_nxt;
  logic [1:0]          grant;
  logic                last;
  logic                owner;
  logic                idle_seen;
  logic                accept;
  logic                gsel;
  logic [5:0]          run_cnt;
  logic [5:0]          run_nxt;
  logic                run_abort;
  logic [SIZE-1:0]     result;
  logic                err;
  logic [KEY_SIZE-1:0] key_q;
  logic [SIZE-1:0]     text_q;

  rr_arb2 u_arb (
    .req   (req_valid),
    .last  (last),
    .grant (grant)
  );

  // idle_seen forces one full IDLE cycle between jobs before a new grant
  assign accept    = (state == S_IDLE) && idle_seen && (grant != 2'b00);
  assign gsel      = grant[1];
  assign run_nxt   = run_cnt + 6'd1;
  assign run_abort = !core_done && (run_nxt == 6'(MAX_RUN));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_RUN;
      S_RUN: begin
        if (core_done)      state_nxt = S_CAPT;
        else if (run_abort) state_nxt = S_RESP;
      end
      S_CAPT: state_nxt = S_RESP;
      S_RESP: if (rsp_ready[owner]) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = '0;
    rsp_valid   = '0;
    core_enable = (state == S_RUN);
    if (accept) req_ready = grant;
    if (state == S_RESP) rsp_valid[owner] = 1'b1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      idle_seen <= 1'b0;
      last      <= 1'b1;
      owner     <= 1'b0;
      run_cnt   <= '0;
      result    <= '0;
      err       <= 1'b0;
      key_q     <= '0;
      text_q    <= '0;
    end else begin
      idle_seen <= (state == S_IDLE);
      case (state)
        S_IDLE: if (accept) begin
          owner  <= gsel;
          key_q  <= gsel ? req_key[2*KEY_SIZE-1:KEY_SIZE] : req_key[KEY_SIZE-1:0];
          text_q <= gsel ? req_text[2*SIZE-1:SIZE] : req_text[SIZE-1:0];
          err    <= 1'b0;
          result <= '0;
        end
        S_LOAD: run_cnt <= '0;
        S_RUN: begin
          run_cnt <= run_nxt;
          if (run_abort) begin
            err    <= 1'b1;
            result <= '0;
          end
        end
        S_CAPT: result <= core_result;
        S_RESP: if (rsp_ready[owner]) last <= owner;
        default: ;
      endcase
    end
  end

  assign rsp_data     = result;
  assign rsp_error    = err;
  assign core_key     = key_q;
  assign core_text    = text_q;
  assign core_reset_n = ~Reset;

endmodule
